// File: rtl/axis_burst_packer.sv
// Word FIFO feeding fixed-length, gap-free AXI-Stream bursts with tlast,
// zero-padded flush bursts and a per-burst destination address.
module axis_burst_packer #(
   parameter int unsigned BURST_LEN  = 5,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned ADDR_STEP  = BURST_LEN * 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        flush,
   input  logic [31:0] base_addr,
   input  logic        base_load,
   output logic [31:0] tdata,
   output logic [3:0]  tkeep,
   output logic        tlast,
   output logic        tvalid,
   input  logic        tready,
   output logic [31:0] des_addr,
   output logic [15:0] burst_cnt,
   output logic        busy
);

   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   typedef enum logic {
      S_IDLE,
      S_BURST
   } state_t;

   state_t             r_state;
   state_t             w_state_next;

   logic [31:0]        r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_wptr;
   logic [PTR_W-1:0]   r_rptr;
   logic [CNT_W-1:0]   r_count;
   logic [CNT_W-1:0]   w_count_next;
   logic [BEAT_W-1:0]  r_beat;
   logic               r_flush_pending;
   logic [31:0]        r_des_addr;
   logic [15:0]        r_burst_cnt;

   logic               w_empty;
   logic               w_push;
   logic               w_pop;
   logic               w_hs;
   logic               w_last_hs;
   logic               w_flush_set;
   logic               w_flush_clr;

   assign w_empty   = (r_count == '0);
   assign in_ready  = (r_count < CNT_W'(FIFO_DEPTH)) && !r_flush_pending;
   assign w_push    = in_valid & in_ready;
   assign w_hs      = tvalid & tready;
   assign w_pop     = w_hs & !w_empty;
   assign w_last_hs = w_hs & tlast;

   // Pad beats only occur with flush pending, when no pushes can land.
   assign w_flush_set = flush & !w_empty;
   assign w_flush_clr = w_last_hs & (w_count_next == '0);

   always_comb begin
      w_count_next = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + CNT_W'(1);
         2'b01:   w_count_next = r_count - CNT_W'(1);
         default: w_count_next = r_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         r_count <= w_count_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Launch on the post-push count so tvalid follows the filling push by one clock.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if ((w_count_next >= CNT_W'(BURST_LEN)) ||
                (r_flush_pending && (w_count_next != '0))) begin
               w_state_next = S_BURST;
            end
         end
         S_BURST: begin
            if (w_last_hs) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      tvalid = 1'b0;
      busy   = 1'b0;
      tlast  = 1'b0;
      tdata  = '0;
      tkeep  = '0;
      if (r_state == S_BURST) begin
         tvalid = 1'b1;
         busy   = 1'b1;
         tlast  = (r_beat == BEAT_W'(BURST_LEN - 1));
         if (!w_empty) begin
            tdata = r_mem[r_rptr];
            tkeep = '1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_beat <= '0;
      end else if (w_last_hs) begin
         r_beat <= '0;
      end else if (w_hs) begin
         r_beat <= r_beat + BEAT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flush_pending <= 1'b0;
      end else if (w_flush_clr) begin
         r_flush_pending <= 1'b0;
      end else if (w_flush_set) begin
         r_flush_pending <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_des_addr  <= '0;
         r_burst_cnt <= '0;
      end else begin
         if (w_last_hs) begin
            r_des_addr  <= r_des_addr + 32'(ADDR_STEP);
            r_burst_cnt <= r_burst_cnt + 16'd1;
         end else if ((r_state == S_IDLE) && base_load) begin
            r_des_addr <= base_addr;
         end
      end
   end

   assign des_addr  = r_des_addr;
   assign burst_cnt = r_burst_cnt;

endmodule

// File: tb/tb_axis_burst_packer.sv
// Scoreboard bench for axis_burst_packer: expected beats are queued as words
// are driven and compared as the stream handshakes them.
module tb_axis_burst_packer;

   logic        clk;
   logic        rst_n;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        flush;
   logic [31:0] base_addr;
   logic        base_load;
   logic [31:0] tdata;
   logic [3:0]  tkeep;
   logic        tlast;
   logic        tvalid;
   logic        tready;
   logic [31:0] des_addr;
   logic [15:0] burst_cnt;
   logic        busy;

   axis_burst_packer #(
      .BURST_LEN  (5),
      .FIFO_DEPTH (16),
      .ADDR_STEP  (20)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flush     (flush),
      .base_addr (base_addr),
      .base_load (base_load),
      .tdata     (tdata),
      .tkeep     (tkeep),
      .tlast     (tlast),
      .tvalid    (tvalid),
      .tready    (tready),
      .des_addr  (des_addr),
      .burst_cnt (burst_cnt),
      .busy      (busy)
   );

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
   } beat_t;

   beat_t       exp_q[$];
   int          n_checks = 0;
   int          n_err    = 0;
   int          m_words  = 0;
   int          m_beats_q = 0;
   int          mon_idx  = 0;
   bit          m_flush  = 0;
   logic [31:0] m_addr   = '0;
   logic [15:0] m_bursts = '0;
   logic [31:0] addr_snap;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic bit exp_ready();
      return (m_words < 16) && !m_flush;
   endfunction

   // Stream monitor: a beat handshakes at the posedge following this negedge.
   initial begin
      beat_t b;
      forever begin
         @(negedge clk);
         if (rst_n && tvalid && tready) begin
            if (exp_q.size() == 0) begin
               check("spurious_beat", 32'(tvalid), 32'd0);
            end else begin
               b = exp_q.pop_front();
               check("tdata", tdata, b.data);
               check("tkeep", 32'(tkeep), 32'(b.keep));
               check("tlast", 32'(tlast), 32'(mon_idx == 4));
               check("des_addr_beat", des_addr, m_addr);
               check("burst_cnt_beat", 32'(burst_cnt), 32'(m_bursts));
               if (b.keep == 4'hF) m_words--;
               if (mon_idx == 4) begin
                  mon_idx  = 0;
                  m_addr   = m_addr + 32'h14;
                  m_bursts = m_bursts + 16'd1;
                  if (m_words == 0) m_flush = 0;
               end else begin
                  mon_idx++;
               end
            end
         end
      end
   end

   // All tasks start and end at posedge+1.
   task automatic push_word(input logic [31:0] w);
      bit ok;
      ok       = exp_ready();
      in_data  = w;
      in_valid = 1'b1;
      check("in_ready", 32'(in_ready), 32'(ok));
      if (ok) begin
         exp_q.push_back(beat_t'{data: w, keep: 4'hF});
         m_words++;
         m_beats_q++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic pulse_flush();
      int pad;
      flush = 1'b1;
      if (m_words != 0) begin
         m_flush = 1;
         pad = (5 - (m_beats_q % 5)) % 5;
         for (int i = 0; i < pad; i++) exp_q.push_back(beat_t'{data: 32'h0, keep: 4'h0});
         m_beats_q += pad;
      end
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_in_ready", 32'(in_ready), 32'(exp_ready()));
   endtask

   task automatic load_base(input logic [31:0] a, input bit idle);
      base_addr = a;
      base_load = 1'b1;
      @(posedge clk); #1;
      base_load = 1'b0;
      if (idle) m_addr = a;
      check("des_addr_load", des_addr, m_addr);
   endtask

   task automatic wait_tvalid();
      int i;
      i = 0;
      while (!tvalid && i < 50) begin
         @(posedge clk); #1;
         i++;
      end
      check("tvalid_wait", 32'(tvalid), 32'd1);
   endtask

   task automatic wait_drain(input int n);
      int i;
      i = 0;
      while (exp_q.size() != n && i < 400) begin
         @(posedge clk);
         i++;
      end
      #1;
      check("drain_timeout", 32'(exp_q.size()), 32'(n));
      repeat (2) @(posedge clk);
      #1;
      check("idle_tvalid", 32'(tvalid), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; in_data = '0; in_valid = 1'b0; flush = 1'b0;
      base_addr = '0; base_load = 1'b0; tready = 1'b0;
      #1;
      check("rst_tvalid", 32'(tvalid), 32'd0);
      check("rst_tlast", 32'(tlast), 32'd0);
      check("rst_tdata", tdata, 32'd0);
      check("rst_tkeep", 32'(tkeep), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_des_addr", des_addr, 32'd0);
      check("rst_burst_cnt", 32'(burst_cnt), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Single burst with tready high
      load_base(32'h1000, 1);
      tready = 1'b1;
      for (int i = 1; i <= 4; i++) push_word(32'(i));
      check("tvalid_before_fill", 32'(tvalid), 32'd0);
      push_word(32'h5);
      check("tvalid_rise", 32'(tvalid), 32'd1);
      wait_drain(0);
      check("t1_des_addr", des_addr, 32'h1014);
      check("t1_burst_cnt", 32'(burst_cnt), 32'd1);

      // Backpressure: 12 words, tready low for 10 cycles
      tready = 1'b0;
      for (int i = 0; i < 12; i++) push_word(32'h100 + 32'(i));
      for (int i = 0; i < 10; i++) begin
         check("stall_tvalid", 32'(tvalid), 32'd1);
         check("stall_tdata", tdata, exp_q[0].data);
         check("stall_tlast", 32'(tlast), 32'd0);
         check("stall_des_addr", des_addr, m_addr);
         @(posedge clk); #1;
      end
      tready = 1'b1;
      wait_drain(2);
      check("t2_des_addr", des_addr, 32'h103C);
      check("t2_burst_cnt", 32'(burst_cnt), 32'd3);
      pulse_flush();
      wait_drain(0);

      // Flush of a short burst
      push_word(32'hA);
      push_word(32'hB);
      push_word(32'hC);
      pulse_flush();
      check("flush_ready_low", 32'(in_ready), 32'd0);
      wait_drain(0);
      check("flush_ready_back", 32'(in_ready), 32'd1);
      check("t3_burst_cnt", 32'(burst_cnt), 32'd5);

      // FIFO full
      tready = 1'b0;
      for (int i = 0; i < 16; i++) push_word(32'h200 + 32'(i));
      check("full_ready", 32'(in_ready), 32'd0);
      push_word(32'hDEAD);
      tready = 1'b1;
      wait_drain(1);
      check("t4_burst_cnt", 32'(burst_cnt), 32'd8);
      pulse_flush();
      wait_drain(0);

      // base_load ignored mid-burst, honoured in IDLE
      tready = 1'b0;
      for (int i = 0; i < 5; i++) push_word(32'h300 + 32'(i));
      wait_tvalid();
      addr_snap = m_addr;
      load_base(32'h2000, 0);
      tready = 1'b1;
      wait_drain(0);
      check("t5_des_addr_step", des_addr, addr_snap + 32'h14);
      load_base(32'h2000, 1);
      check("t5_des_addr_idle", des_addr, 32'h2000);

      // Reset during beat 2
      tready = 1'b0;
      for (int i = 0; i < 5; i++) push_word(32'h400 + 32'(i));
      wait_tvalid();
      tready = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      tready = 1'b0;
      check("beat2_data", tdata, exp_q[0].data);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_tvalid", 32'(tvalid), 32'd0);
      check("mid_rst_tkeep", 32'(tkeep), 32'd0);
      check("mid_rst_des_addr", des_addr, 32'd0);
      check("mid_rst_burst_cnt", 32'(burst_cnt), 32'd0);
      exp_q.delete();
      m_words = 0; m_beats_q = 0; mon_idx = 0; m_flush = 0;
      m_addr = '0; m_bursts = '0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      check("post_rst_tvalid", 32'(tvalid), 32'd0);
      tready = 1'b1;
      for (int i = 0; i < 5; i++) push_word(32'h500 + 32'(i));
      wait_drain(0);
      check("t6_des_addr", des_addr, 32'h14);
      check("t6_burst_cnt", 32'(burst_cnt), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/axis_burst_packer.md
# axis_burst_packer

Upstream feeder for the AXI-Stream-to-AXI write bridge. It collects a free-running 32-bit word stream from the core into a FIFO and emits fixed-length AXI-Stream bursts of BURST_LEN contiguous beats with tlast on the final beat. It also supplies the bridge with a stable per-burst destination address that advances by one burst after each completed packet. Every emitted burst is gap-free, so the bridge can consume one beat per cycle once it asserts tready.

## Interface
- BURST_LEN, 5: beats per burst; matches the bridge's awlen+1.
- FIFO_DEPTH, 16: word FIFO depth; power of two, >= BURST_LEN.
- ADDR_STEP, BURST_LEN*4: byte increment of des_addr per completed burst.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  32  input word.
- in_valid  in  1  input word valid.
- in_ready  out  1  input accept; high when FIFO count < FIFO_DEPTH and no flush pending.
- flush  in  1  single-cycle request to emit remaining words as a zero-padded burst.
- base_addr  in  32  burst base address.
- base_load  in  1  loads des_addr from base_addr; honoured in IDLE only.
- tdata  out  32  stream data.
- tkeep  out  4  4'hF on real beats, 4'h0 on pad beats.
- tlast  out  1  high on beat BURST_LEN-1.
- tvalid  out  1  stream valid.
- tready  in  1  stream ready from the bridge.
- des_addr  out  32  destination address of the current or next burst.
- burst_cnt  out  16  completed bursts; wraps at 2^16.
- busy  out  1  high in BURST state.

## Operation
- FIFO push when in_valid & in_ready. Pop on a real-beat handshake (tvalid & tready while FIFO non-empty).
- Push and pop in the same cycle leave the count unchanged. Count width is clog2(FIFO_DEPTH)+1, and read/write pointers wrap modulo FIFO_DEPTH.
- State IDLE transitions to BURST when count >= BURST_LEN, or when flush_pending & count > 0. Otherwise it stays in IDLE.
- In BURST:
  - tvalid = 1 every cycle until the tlast handshake.
  - beat counter runs 0..BURST_LEN-1 and advances only on tvalid & tready.
  - tlast = (beat == BURST_LEN-1).
  - tdata = FIFO head and tkeep = 4'hF if the FIFO is non-empty; otherwise tdata = 0 and tkeep = 4'h0 (pad beat).
- On the tlast handshake:
  - beat counter clears to 0.
  - des_addr advances by ADDR_STEP (modulo 2^32).
  - burst_cnt increments.
  - state returns to IDLE.
- flush:
  - Sets flush_pending; in_ready drops while it is set.
  - flush_pending clears at the tlast handshake that leaves count == 0.
  - flush with count == 0 in IDLE is a no-op and does not set the flag.
- base_load:
  - In IDLE, des_addr <= base_addr.
  - In BURST it is ignored, so a tlast-handshake increment always wins.
- des_addr is held constant for the whole of a burst.

## Timing
- Reset values:
  - state = IDLE; FIFO empty with pointers 0; beat = 0.
  - flush_pending = 0, des_addr = 0, burst_cnt = 0.
  - tvalid = 0, tlast = 0, tdata = 0, tkeep = 0, busy = 0.
  - in_ready = 1 after reset deasserts.
- Reset mid-burst discards FIFO contents and the partial burst; the stream outputs drop asynchronously.
- tvalid rises one cycle after the push that makes count reach BURST_LEN; fall-through latency is 1 clock.
- Once tvalid is high, tdata, tkeep, tlast and des_addr hold stable while tready is low.
- In BURST with tready held high, BURST_LEN beats go out on consecutive cycles.
- tvalid is low for at least one cycle (the IDLE cycle) between bursts.
- in_ready is registered-count based: it deasserts the cycle after count reaches FIFO_DEPTH and reasserts the cycle after a pop.

## Test plan
- Push 5 words 0x1..0x5 with base_load 0x1000 and tready = 1 → tvalid rises one cycle after the 5th push; 5 contiguous beats 0x1..0x5, tkeep F, tlast on beat 4; des_addr then reads 0x1014 and burst_cnt = 1.
- Push 12 words, then hold tready low for 10 cycles → tvalid high with tdata = word 0 held stable; after release, 2 bursts complete with des_addr stepping by 0x14 and 2 words left in the FIFO.
- Push 3 words 0xA/0xB/0xC, then pulse flush → one burst 0xA, 0xB, 0xC, 0, 0 with tkeep F, F, F, 0, 0; in_ready low until its tlast handshake, then high again.
- Push 16 words with tready = 0 → in_ready = 0 and count holds at 16; a 17th in_valid word is not accepted; with tready = 1 all 16 words drain as 3 full bursts and 1 word remains.
- Assert base_load 0x2000 mid-burst → ignored; des_addr advances by 0x14 at tlast; the same load issued in IDLE sets 0x2000.
- Assert rst_n low during beat 2 → tvalid = 0 immediately, FIFO empty, des_addr = 0, burst_cnt = 0; the next burst after reset starts at beat 0.
